// File: rtl/d_cache_nway_wb_pkg.sv
// rtl/d_cache_nway_wb_pkg.sv - shared state encoding, size codes and byte-lane helpers for the data cache
package d_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_RF   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Byte lanes touched by a store of the given size at the given byte offset
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: byte_mask = 4'b0001 << addr_lo;
      SIZE_HALF: byte_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   byte_mask = 4'b1111;
    endcase
  endfunction

  // Replace the masked byte lanes of old_word with the lane-aligned store data
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  mask);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) result[8*b +: 8] = wdata[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/d_cache_nway_wb_lru.sv
// rtl/d_cache_nway_wb_lru.sv - per-set age-based LRU bookkeeping with touch and victim ports
module cache_lru_set #(
  parameter int WAYS        = 4,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     touch_en,
  input  logic [INDEX_WIDTH-1:0]   touch_index,
  input  logic [$clog2(WAYS)-1:0]  touch_way,
  input  logic [INDEX_WIDTH-1:0]   victim_index,
  output logic [$clog2(WAYS)-1:0]  victim_way
);

  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WAY_W = $clog2(WAYS);

  // Ages within a set are always a permutation of 0..WAYS-1; 0 is most recent
  logic [WAY_W-1:0] age [SETS][WAYS];

  // Touch: younger-than-touched ways age by one, touched way becomes youngest
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age[s][w] <= WAY_W'(w);
        end
      end
    end else if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way) begin
          age[touch_index][w] <= '0;
        end else if (age[touch_index][w] < age[touch_index][touch_way]) begin
          age[touch_index][w] <= age[touch_index][w] + 1'b1;
        end
      end
    end
  end

  // Victim is the single way holding the oldest age
  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age[victim_index][w] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(w);
    end
  end

endmodule

// File: rtl/d_cache_nway_wb.sv
// rtl/d_cache_nway_wb.sv - N-way set-associative write-back/write-allocate data cache with multi-word lines
module d_cache_nway_wb #(
  parameter int WAYS         = 4,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  import d_cache_pkg::*;

  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int WORD_W    = OFFSET_WIDTH - 2;
  localparam int WPL       = 1 << WORD_W;
  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WAY_W     = $clog2(WAYS);

  // Line storage
  logic [TAG_WIDTH-1:0] tag_arr   [WAYS][SETS];
  logic [31:0]          data_arr  [WAYS][SETS][WPL];
  logic [SETS-1:0]      valid_arr [WAYS];
  logic [SETS-1:0]      dirty_arr [WAYS];

  // Miss bookkeeping
  state_t            state;
  logic              req_r;
  logic [WORD_W-1:0] wcnt;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;
  logic              wr_r;
  logic [1:0]        size_r;
  logic [WAY_W-1:0]  vic_r;

  // Live request fields
  logic [TAG_WIDTH-1:0]   cpu_tag;
  logic [INDEX_WIDTH-1:0] cpu_idx;
  logic [WORD_W-1:0]      cpu_word;
  assign cpu_tag  = cpu_data_addr[31 -: TAG_WIDTH];
  assign cpu_idx  = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign cpu_word = cpu_data_addr[2 +: WORD_W];

  // Latched request fields
  logic [TAG_WIDTH-1:0]   tag_r;
  logic [INDEX_WIDTH-1:0] idx_r;
  logic [WORD_W-1:0]      word_r;
  assign tag_r  = addr_r[31 -: TAG_WIDTH];
  assign idx_r  = addr_r[OFFSET_WIDTH +: INDEX_WIDTH];
  assign word_r = addr_r[2 +: WORD_W];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             has_invalid;
  logic [WAY_W-1:0] invalid_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] victim_way;
  logic             victim_dirty;
  logic [31:0]      hit_word;
  logic             idle_req;
  logic             hit_go;
  logic             miss_go;
  logic             last_word;

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_arr[w][cpu_idx] && (tag_arr[w][cpu_idx] == cpu_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-index invalid way, scanned downward so the lowest one wins
  always_comb begin
    has_invalid = 1'b0;
    invalid_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_arr[w][cpu_idx]) begin
        has_invalid = 1'b1;
        invalid_way = WAY_W'(w);
      end
    end
  end

  assign victim_way   = has_invalid ? invalid_way : lru_way;
  assign victim_dirty = valid_arr[victim_way][cpu_idx] && dirty_arr[victim_way][cpu_idx];
  assign hit_word     = data_arr[hit_way][cpu_idx][cpu_word];
  assign idle_req     = (state == ST_IDLE) && cpu_data_req;
  assign hit_go       = idle_req && hit;
  assign miss_go      = idle_req && !hit;
  assign last_word    = (wcnt == WORD_W'(WPL - 1));

  cache_lru_set #(
    .WAYS        (WAYS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_lru (
    .clk          (clk),
    .rst          (rst),
    .touch_en     (hit_go || (state == ST_DONE)),
    .touch_index  ((state == ST_DONE) ? idx_r : cpu_idx),
    .touch_way    ((state == ST_DONE) ? vic_r : hit_way),
    .victim_index (cpu_idx),
    .victim_way   (lru_way)
  );

  // Control FSM: request latch, word counter, memory request and valid/dirty state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      req_r   <= 1'b0;
      wcnt    <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      wr_r    <= 1'b0;
      size_r  <= '0;
      vic_r   <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_arr[w] <= '0;
        dirty_arr[w] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit_go && cpu_data_wr) dirty_arr[hit_way][cpu_idx] <= 1'b1;
          if (miss_go) begin
            addr_r  <= cpu_data_addr;
            wdata_r <= cpu_data_wdata;
            wr_r    <= cpu_data_wr;
            size_r  <= cpu_data_size;
            vic_r   <= victim_way;
            wcnt    <= '0;
            req_r   <= 1'b1;
            state   <= victim_dirty ? ST_WB : ST_RF;
          end
        end
        ST_WB: begin
          if (cache_data_data_ok) begin
            // Next word (or first refill word) is requested straight away
            req_r <= 1'b1;
            wcnt  <= last_word ? '0 : wcnt + 1'b1;
            if (last_word) state <= ST_RF;
          end else if (cache_data_addr_ok) begin
            req_r <= 1'b0;
          end
        end
        ST_RF: begin
          if (cache_data_data_ok) begin
            if (wcnt == word_r) rdata_r <= cache_data_rdata;
            if (last_word) begin
              valid_arr[vic_r][idx_r] <= 1'b1;
              dirty_arr[vic_r][idx_r] <= 1'b0;
              req_r <= 1'b0;
              wcnt  <= '0;
              state <= ST_DONE;
            end else begin
              req_r <= 1'b1;
              wcnt  <= wcnt + 1'b1;
            end
          end else if (cache_data_addr_ok) begin
            req_r <= 1'b0;
          end
        end
        ST_DONE: begin
          if (wr_r) dirty_arr[vic_r][idx_r] <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag and data array writes: store hits, refill words, and the deferred miss store
  always_ff @(posedge clk) begin
    if (hit_go && cpu_data_wr) begin
      data_arr[hit_way][cpu_idx][cpu_word] <=
        merge_word(hit_word, cpu_data_wdata, byte_mask(cpu_data_size, cpu_data_addr[1:0]));
    end
    if ((state == ST_RF) && cache_data_data_ok) begin
      data_arr[vic_r][idx_r][wcnt] <= cache_data_rdata;
      if (last_word) tag_arr[vic_r][idx_r] <= tag_r;
    end
    if ((state == ST_DONE) && wr_r) begin
      data_arr[vic_r][idx_r][word_r] <=
        merge_word(data_arr[vic_r][idx_r][word_r], wdata_r, byte_mask(size_r, addr_r[1:0]));
    end
  end

  assign cpu_data_addr_ok = rst && idle_req;
  assign cpu_data_data_ok = rst && (hit_go || (state == ST_DONE));
  assign cpu_data_rdata   = (!rst)              ? 32'd0    :
                            hit_go              ? hit_word :
                            (state == ST_DONE)  ? rdata_r  : 32'd0;

  assign cache_data_req   = req_r;
  assign cache_data_wr    = (state == ST_WB);
  assign cache_data_size  = SIZE_WORD;
  assign cache_data_addr  = (state == ST_WB) ? {tag_arr[vic_r][idx_r], idx_r, wcnt, 2'b00} :
                            (state == ST_RF) ? {tag_r, idx_r, wcnt, 2'b00} : 32'd0;
  assign cache_data_wdata = (state == ST_WB) ? data_arr[vic_r][idx_r][wcnt] : 32'd0;

endmodule

// File: tb/tb_d_cache_nway_wb.sv
// tb/tb_d_cache_nway_wb.sv - self-checking bench for d_cache_nway_wb
module tb_d_cache_nway_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_data_req;
  logic        cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok;
  logic        cpu_data_data_ok;
  logic        cache_data_req;
  logic        cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr;
  logic [31:0] cache_data_wdata;
  logic [31:0] cache_data_rdata;
  logic        cache_data_addr_ok;
  logic        cache_data_data_ok;

  d_cache_nway_wb dut (
    .clk                (clk),
    .rst                (rst),
    .cpu_data_req       (cpu_data_req),
    .cpu_data_wr        (cpu_data_wr),
    .cpu_data_size      (cpu_data_size),
    .cpu_data_addr      (cpu_data_addr),
    .cpu_data_wdata     (cpu_data_wdata),
    .cpu_data_rdata     (cpu_data_rdata),
    .cpu_data_addr_ok   (cpu_data_addr_ok),
    .cpu_data_data_ok   (cpu_data_data_ok),
    .cache_data_req     (cache_data_req),
    .cache_data_wr      (cache_data_wr),
    .cache_data_size    (cache_data_size),
    .cache_data_addr    (cache_data_addr),
    .cache_data_wdata   (cache_data_wdata),
    .cache_data_rdata   (cache_data_rdata),
    .cache_data_addr_ok (cache_data_addr_ok),
    .cache_data_data_ok (cache_data_data_ok)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc, done_cyc, last_dok_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model state
  typedef struct {
    logic        wr;
    logic [31:0] addr;
  } op_t;

  logic [31:0] mem [logic [31:0]];
  op_t         log_q [$];
  bit          mem_fast = 1'b0;
  bit          pend     = 1'b0;
  logic        pend_wr;
  logic [31:0] pend_addr, pend_wdata;

  logic [31:0] exp_q [$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic mem_complete(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    if (wr) mem[a] = wd;
    else    cache_data_rdata = mem_rd(a);
    cache_data_data_ok = 1'b1;
    last_dok_cyc = cyc;
  endtask

  // Sram-like memory: slow mode answers data one cycle after address, fast mode in the same cycle
  initial begin
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    cache_data_rdata   = 32'd0;
    mem[32'h0000_1000] = 32'h1122_3344;
    forever begin
      @(negedge clk);
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      if (!rst) begin
        pend = 1'b0;
      end else if (pend) begin
        pend = 1'b0;
        mem_complete(pend_wr, pend_addr, pend_wdata);
      end else if (cache_data_req) begin
        cache_data_addr_ok = 1'b1;
        log_q.push_back('{wr: cache_data_wr, addr: cache_data_addr});
        if (mem_fast) begin
          mem_complete(cache_data_wr, cache_data_addr, cache_data_wdata);
        end else begin
          pend       = 1'b1;
          pend_wr    = cache_data_wr;
          pend_addr  = cache_data_addr;
          pend_wdata = cache_data_wdata;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected load completion rdata %h", name, cpu_data_rdata);
    end else begin
      chk({name, " rdata"}, cpu_data_rdata, exp_q.pop_front());
    end
  endtask

  task automatic access(input string name, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input logic exp_hit, input int exp_ops);
    int ops0;
    bit got;
    ops0 = log_q.size();
    @(negedge clk);
    cpu_data_req   = 1'b1;
    cpu_data_wr    = wr;
    cpu_data_size  = size;
    cpu_data_addr  = addr;
    cpu_data_wdata = wdata;
    if (!wr) exp_q.push_back(exp);
    #1;
    chk({name, " addr_ok"}, 32'(cpu_data_addr_ok), 32'd1);
    chk({name, " hit"}, 32'(cpu_data_data_ok), 32'(exp_hit));
    acc_cyc = cyc;
    got = cpu_data_data_ok;
    if (got) begin
      done_cyc = cyc;
      if (!wr) sb_pop(name);
    end
    @(posedge clk);
    #1;
    cpu_data_req  = 1'b0;
    cpu_data_addr = 32'hFFFF_FFFC;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      #1;
      if (cpu_data_data_ok) begin
        got = 1'b1;
        done_cyc = cyc;
        if (!wr) sb_pop(name);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s: no data_ok within 400 cycles", name);
      exp_q.delete();
    end
    chk({name, " mem ops"}, 32'(log_q.size() - ops0), 32'(exp_ops));
  endtask

  task automatic chk_ops(input string name, input int base, input int n,
                         input logic wr, input logic [31:0] addr0);
    for (int i = 0; i < n; i++) begin
      if (base + i < log_q.size()) begin
        chk($sformatf("%s op%0d wr", name, i), 32'(log_q[base + i].wr), 32'(wr));
        chk($sformatf("%s op%0d addr", name, i), log_q[base + i].addr, addr0 + 32'(4 * i));
      end else begin
        checks++;
        failures++;
        $display("FAIL %s op%0d: missing memory transfer", name, i);
      end
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, " cpu addr_ok"}, 32'(cpu_data_addr_ok), 32'd0);
    chk({name, " cpu data_ok"}, 32'(cpu_data_data_ok), 32'd0);
    chk({name, " cpu rdata"}, cpu_data_rdata, 32'd0);
    chk({name, " mem req"}, 32'(cache_data_req), 32'd0);
    chk({name, " mem wr"}, 32'(cache_data_wr), 32'd0);
    chk({name, " mem size"}, 32'(cache_data_size), 32'd2);
    chk({name, " mem addr"}, cache_data_addr, 32'd0);
    chk({name, " mem wdata"}, cache_data_wdata, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        hit;
    int          ops;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int  base;
    bit  found;

    vecs.push_back('{"t2_lw_hit",    1'b0, 2'd2, 32'h0000_1008, 32'h0,          32'h5A5A_1008, 1'b1, 0});
    vecs.push_back('{"t3_sb",        1'b1, 2'd0, 32'h0000_1001, 32'h0000_AB00, 32'h0,          1'b1, 0});
    vecs.push_back('{"t3_lw",        1'b0, 2'd2, 32'h0000_1000, 32'h0,          32'h1122_AB44, 1'b1, 0});
    vecs.push_back('{"sh_hi",        1'b1, 2'd1, 32'h0000_1006, 32'hBEEF_0000, 32'h0,          1'b1, 0});
    vecs.push_back('{"lw_after_sh",  1'b0, 2'd2, 32'h0000_1004, 32'h0,          32'hBEEF_1004, 1'b1, 0});
    vecs.push_back('{"fill_t1",      1'b0, 2'd2, 32'h0000_0410, 32'h0,          32'h5A5A_0410, 1'b0, 4});
    vecs.push_back('{"fill_t2_sw",   1'b1, 2'd2, 32'h0000_0810, 32'hCAFE_F00D, 32'h0,          1'b0, 4});
    vecs.push_back('{"t2_hit_sw",    1'b0, 2'd2, 32'h0000_0810, 32'h0,          32'hCAFE_F00D, 1'b1, 0});
    vecs.push_back('{"fill_t3",      1'b0, 2'd2, 32'h0000_0C10, 32'h0,          32'h5A5A_0C10, 1'b0, 4});
    vecs.push_back('{"fill_t4",      1'b0, 2'd2, 32'h0000_1010, 32'h0,          32'h5A5A_1010, 1'b0, 4});
    vecs.push_back('{"touch_t1",     1'b0, 2'd2, 32'h0000_0410, 32'h0,          32'h5A5A_0410, 1'b1, 0});

    rst            = 1'b0;
    cpu_data_req   = 1'b0;
    cpu_data_wr    = 1'b0;
    cpu_data_size  = 2'd0;
    cpu_data_addr  = 32'd0;
    cpu_data_wdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Cold load: four refill reads of the line, then completion one cycle after the last data_ok
    base = log_q.size();
    access("t1_cold", 1'b0, 2'd2, 32'h0000_1004, 32'h0, 32'h5A5A_1004, 1'b0, 4);
    chk_ops("t1_cold", base, 4, 1'b0, 32'h0000_1000);
    chk("t1_cold latency", 32'(done_cyc - last_dok_cyc), 32'd1);

    foreach (vecs[i]) begin
      access(vecs[i].name, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp, vecs[i].hit, vecs[i].ops);
    end

    // LRU victim is tag 2 (dirty): four write-backs then four refill reads
    base = log_q.size();
    access("t4_evict", 1'b0, 2'd2, 32'h0000_1410, 32'h0, 32'h5A5A_1410, 1'b0, 8);
    chk_ops("t4_wb", base, 4, 1'b1, 32'h0000_0810);
    chk_ops("t4_rf", base + 4, 4, 1'b0, 32'h0000_1410);
    access("t4_reload", 1'b0, 2'd2, 32'h0000_0810, 32'h0, 32'hCAFE_F00D, 1'b0, 4);
    access("t4_t4_kept", 1'b0, 2'd2, 32'h0000_1014, 32'h0, 32'h5A5A_1014, 1'b1, 0);

    // Same-cycle addr_ok/data_ok memory: one transfer per cycle, no duplicates
    mem_fast = 1'b1;
    base = log_q.size();
    access("t5_fast", 1'b0, 2'd2, 32'h0000_2054, 32'h0, 32'h5A5A_2054, 1'b0, 4);
    chk_ops("t5_fast", base, 4, 1'b0, 32'h0000_2050);
    chk("t5_fast cycles", 32'(done_cyc - acc_cyc), 32'd5);
    mem_fast = 1'b0;

    // Reset while refill word 2 is being requested
    @(negedge clk);
    cpu_data_req  = 1'b1;
    cpu_data_wr   = 1'b0;
    cpu_data_size = 2'd2;
    cpu_data_addr = 32'h0000_3060;
    #1;
    chk("t6 addr_ok", 32'(cpu_data_addr_ok), 32'd1);
    @(posedge clk);
    #1;
    cpu_data_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (cache_data_req && (cache_data_addr == 32'h0000_3068)) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL t6: refill word 2 request not seen within 100 cycles");
    end
    #1;
    rst = 1'b0;
    #1;
    chk_outputs_zero("t6_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    access("t6_refetch", 1'b0, 2'd2, 32'h0000_3060, 32'h0, 32'h5A5A_3060, 1'b0, 4);
    access("t6_lost_line", 1'b0, 2'd2, 32'h0000_1004, 32'h0, 32'h5A5A_1004, 1'b0, 4);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: %0d loads never completed", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
